// File: rtl/rager_pkg.sv
// Shared types for the player projectile pool.
// Slot layout, FSM encoding and the fire keycode.
package rager_pkg;

  localparam logic [7:0] FIRE_KEY = 8'h2C;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } bullet_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SPAWN
  } bullet_state_e;

endpackage

// File: rtl/bullet_pixel_test.sv
// Combinational sprite hit test of one slot
// against the current pixel query.
module bullet_pixel_test
  import rager_pkg::*;
#(
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 4
) (
  input  bullet_t b_i,
  input  coord_t  draw_x_i,
  input  coord_t  draw_y_i,
  output logic    hit_o
);

  localparam coord_t W = coord_t'(BULLET_W);
  localparam coord_t H = coord_t'(BULLET_H);

  coord_t dx;
  coord_t dy;

  // Differences only matter once the >= guards hold.
  assign dx = draw_x_i - b_i.x;
  assign dy = draw_y_i - b_i.y;

  assign hit_o = b_i.valid
    && (draw_x_i >= b_i.x) && (dx < W)
    && (draw_y_i >= b_i.y) && (dy < H);

endmodule

// File: rtl/bullet_ctrl.sv
// Frame-sequenced projectile pool: per-frame slot walk,
// one spawn decision, and a registered pixel query.
module bullet_ctrl
  import rager_pkg::*;
#(
  parameter int NUM_BULLETS  = 4,
  parameter int BULLET_SPEED = 4,
  parameter int COOLDOWN     = 8,
  parameter int SPAWN_OFFSET = 8,
  parameter int BULLET_W     = 2,
  parameter int BULLET_H     = 4,
  localparam int CW = $clog2(NUM_BULLETS + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_start,
  input  logic          Start,
  input  logic [7:0]    keycodeshoot,
  input  logic [9:0]    Ball_X,
  input  logic [9:0]    Ball_Y,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  output logic          bullet_on,
  output logic [CW-1:0] active_count,
  output logic          pool_full,
  output logic          busy,
  output logic          spawn,
  output logic          overrun
);

  localparam int IW =
    (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CDW =
    (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam coord_t SPEED  = coord_t'(BULLET_SPEED);
  localparam coord_t OFFSET = coord_t'(SPAWN_OFFSET);
  localparam logic [IW-1:0] LAST =
    IW'(NUM_BULLETS - 1);
  localparam logic [CDW-1:0] CD_INIT = CDW'(COOLDOWN);

  bullet_state_e  state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CDW-1:0] cd_q, cd_d;
  bullet_t        slots_q [NUM_BULLETS];
  bullet_t        slots_d [NUM_BULLETS];
  logic [CW-1:0]  count_q;
  logic           full_q;
  logic           on_q;

  logic           has_free;
  logic [IW-1:0]  free_idx;
  logic [CW-1:0]  cnt;
  logic           fire;
  logic [NUM_BULLETS-1:0] hit;

  assign fire = (keycodeshoot == FIRE_KEY);

  // Lowest-index free slot wins.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      cnt = cnt + CW'(slots_q[i].valid);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cd_d    = cd_q;
    spawn   = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      slots_d[i] = slots_q[i];
    end
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (!Start) begin
          slots_d[idx_q].valid = 1'b0;
        end else if (slots_q[idx_q].valid
                     && slots_q[idx_q].y < SPEED) begin
          slots_d[idx_q].valid = 1'b0;
        end else if (slots_q[idx_q].valid) begin
          slots_d[idx_q].y = slots_q[idx_q].y - SPEED;
        end
        if (idx_q == LAST) begin
          state_d = SPAWN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SPAWN: begin
        state_d = IDLE;
        if (!Start) begin
          cd_d = '0;
        end else if (cd_q != '0) begin
          cd_d = cd_q - 1'b1;
        end else if (fire && has_free
                     && Ball_Y >= OFFSET) begin
          slots_d[free_idx].valid = 1'b1;
          slots_d[free_idx].x     = Ball_X;
          slots_d[free_idx].y     = Ball_Y - OFFSET;
          cd_d  = CD_INIT;
          spawn = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_hit
    bullet_pixel_test #(
      .BULLET_W (BULLET_W),
      .BULLET_H (BULLET_H)
    ) u_hit (
      .b_i      (slots_q[g]),
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .hit_o    (hit[g])
    );
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      on_q    <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cd_q    <= cd_d;
      count_q <= cnt;
      full_q  <= (cnt == CW'(NUM_BULLETS));
      on_q    <= |hit;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        slots_q[i] <= slots_d[i];
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign overrun      = frame_start && busy;
  assign bullet_on    = on_q;
  assign active_count = count_q;
  assign pool_full    = full_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scoreboard bench for bullet_ctrl: frame passes,
// spawn/cooldown, pool reuse, pixel query, overrun.
module tb_bullet_ctrl;

  localparam int N   = 4;
  localparam int SPD = 4;
  localparam int CD  = 8;
  localparam int OFS = 8;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] keycodeshoot = 8'h00;
  logic [9:0] Ball_X = '0;
  logic [9:0] Ball_Y = '0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       bullet_on;
  logic [2:0] active_count;
  logic       pool_full;
  logic       busy;
  logic       spawn;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  bit mv [N];
  int mx [N];
  int my [N];
  int mcd;

  bit spawn_q [$];
  bit pix_q [$];

  always #5 Clk = ~Clk;

  bullet_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .Start        (Start),
    .keycodeshoot (keycodeshoot),
    .Ball_X       (Ball_X),
    .Ball_Y       (Ball_Y),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .bullet_on    (bullet_on),
    .active_count (active_count),
    .pool_full    (pool_full),
    .busy         (busy),
    .spawn        (spawn),
    .overrun      (overrun)
  );

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mv[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mx[i] = 0; my[i] = 0;
    end
    mcd = 0;
  endtask

  task automatic model_pass(output bit sp);
    bit fire;
    bit done;
    fire = (keycodeshoot == 8'h2C);
    for (int i = 0; i < N; i++) begin
      if (!Start) mv[i] = 0;
      else if (mv[i] && my[i] < SPD) mv[i] = 0;
      else if (mv[i]) my[i] -= SPD;
    end
    sp = 0;
    if (!Start) mcd = 0;
    else if (mcd != 0) mcd--;
    else if (fire && mcount() < N
             && int'(Ball_Y) >= OFS) begin
      done = 0;
      for (int i = 0; i < N; i++) begin
        if (!done && !mv[i]) begin
          mv[i] = 1;
          mx[i] = int'(Ball_X);
          my[i] = int'(Ball_Y) - OFS;
          done = 1;
        end
      end
      mcd = CD;
      sp = 1;
    end
  endtask

  task automatic reset_dut();
    @(negedge Clk);
    Reset_n = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
    spawn_q.delete();
    pix_q.delete();
  endtask

  task automatic run_frame(string tag);
    bit sp;
    bit e;
    int c;
    model_pass(sp);
    spawn_q.push_back(sp);
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy got=%b exp=1", tag, busy);
    end
    repeat (4) @(negedge Clk);
    e = spawn_q.pop_front();
    checks++;
    if (spawn !== e) begin
      failures++;
      $display("FAIL %s spawn got=%b exp=%b",
               tag, spawn, e);
    end
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle got=%b exp=0", tag, busy);
    end
    @(negedge Clk);
    c = mcount();
    checks++;
    if (active_count !== 3'(c)
        || pool_full !== (c == N)) begin
      failures++;
      $display("FAIL %s count got=%0d/%b exp=%0d/%b",
               tag, active_count, pool_full, c, c == N);
    end
  endtask

  task automatic query(int x, int y, bit exp);
    bit e;
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    pix_q.push_back(exp);
    @(negedge Clk);
    e = pix_q.pop_front();
    checks++;
    if (bullet_on !== e) begin
      failures++;
      $display("FAIL pix(%0d,%0d) got=%b exp=%b",
               x, y, bullet_on, e);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bullet_on, active_count, pool_full, busy,
         spawn, overrun} !== 8'h00) begin
      failures++;
      $display("FAIL reset outs got=%b exp=0",
               {bullet_on, active_count, pool_full,
                busy, spawn, overrun});
    end
    reset_dut();
  endtask

  task automatic test_spawn_move();
    reset_dut();
    Start = 1'b1;
    keycodeshoot = 8'h2C;
    Ball_X = 10'd320;
    Ball_Y = 10'd240;
    run_frame("spawn0");
    query(320, 232, 1);
    query(320, 231, 0);
    query(321, 235, 1);
    query(322, 232, 0);
    keycodeshoot = 8'h00;
    run_frame("move1");
    query(320, 228, 1);
    query(320, 232, 0);
  endtask

  task automatic test_autofire();
    reset_dut();
    Start = 1'b1;
    keycodeshoot = 8'h2C;
    Ball_X = 10'd320;
    Ball_Y = 10'd240;
    for (int f = 0; f < 10; f++) run_frame("auto");
    checks++;
    if (active_count !== 3'd2) begin
      failures++;
      $display("FAIL autofire count got=%0d exp=2",
               active_count);
    end
  endtask

  task automatic test_pool_reuse();
    reset_dut();
    Start = 1'b1;
    keycodeshoot = 8'h2C;
    for (int f = 0; f < 38; f++) begin
      if (f == 0) begin
        Ball_X = 10'd10; Ball_Y = 10'd152;
      end else if (f == 37) begin
        Ball_X = 10'd500; Ball_Y = 10'd479;
      end else begin
        Ball_X = 10'd320; Ball_Y = 10'd479;
      end
      run_frame("pool");
      if (f == 36) begin
        checks++;
        if (pool_full !== 1'b1) begin
          failures++;
          $display("FAIL pool_full got=%b exp=1",
                   pool_full);
        end
        query(10, 0, 1);
        query(10, 3, 1);
      end
    end
    query(10, 0, 0);
    query(500, 471, 1);
    query(501, 474, 1);
  endtask

  task automatic test_boundary();
    reset_dut();
    Start = 1'b1;
    keycodeshoot = 8'h2C;
    Ball_X = 10'd50;
    Ball_Y = 10'd7;
    run_frame("low_y");
    Ball_Y = 10'd8;
    run_frame("y_eq_ofs");
    query(50, 0, 1);
    keycodeshoot = 8'h00;
    run_frame("retire0");
    query(50, 0, 0);
    Start = 1'b0;
    run_frame("stop_cd");
    Start = 1'b1;
    keycodeshoot = 8'h2C;
    Ball_X = 10'd60;
    Ball_Y = 10'd100;
    run_frame("restart");
    Start = 1'b0;
    run_frame("clear");
    query(60, 92, 0);
    Start = 1'b1;
    run_frame("respawn");
  endtask

  task automatic test_pixel();
    reset_dut();
    Start = 1'b1;
    keycodeshoot = 8'h2C;
    Ball_X = 10'd100;
    Ball_Y = 10'd58;
    run_frame("pix_spawn");
    query(101, 53, 1);
    query(102, 53, 0);
    query(99, 50, 0);
    query(101, 54, 0);
    query(100, 50, 1);
    query(100, 49, 0);
  endtask

  task automatic test_overrun();
    bit sp;
    bit e;
    keycodeshoot = 8'h00;
    model_pass(sp);
    spawn_q.push_back(sp);
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_t1 got=%b exp=0", overrun);
    end
    @(negedge Clk);
    frame_start = 1'b1;
    #1;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_t2 got=%b exp=1", overrun);
    end
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (2) @(negedge Clk);
    e = spawn_q.pop_front();
    checks++;
    if (spawn !== e) begin
      failures++;
      $display("FAIL ovr spawn got=%b exp=%b", spawn, e);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ovr busy got=%b exp=0", busy);
    end
    query(100, 46, 1);
    query(100, 50, 0);
    query(100, 42, 0);
  endtask

  task automatic test_reset_midpass();
    Start = 1'b1;
    keycodeshoot = 8'h2C;
    Ball_X = 10'd200;
    Ball_Y = 10'd300;
    @(negedge Clk);
    DrawX = 10'd100;
    DrawY = 10'd46;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    @(negedge Clk);
    checks++;
    if (bullet_on !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst on got=%b exp=1", bullet_on);
    end
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, active_count, bullet_on, spawn}
        !== 6'b0) begin
      failures++;
      $display("FAIL midrst got=%b exp=0",
               {busy, active_count, bullet_on, spawn});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
    spawn_q.delete();
    run_frame("post_rst");
    query(200, 292, 1);
    query(100, 46, 0);
  endtask

  initial begin
    test_reset();
    test_spawn_move();
    test_autofire();
    test_pool_reuse();
    test_boundary();
    test_pixel();
    test_overrun();
    test_reset_midpass();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bullet_ctrl.md
Name: bullet_ctrl

Overview:
Frame-sequenced scheduler for a pool of player projectiles.
- On each frame pulse it walks every bullet slot one per clock, advances or retires each slot, then makes at most one spawn decision from the shoot keycode, the ball position and a cooldown timer.
- Sits between the USB keycode export and color_mapper.
- Answers a registered per-pixel "bullet here" query driven by DrawX/DrawY.

Parameters:
NUM_BULLETS, 4, number of slots in the pool (1..8)
BULLET_SPEED, 4, pixels moved upward per frame
COOLDOWN, 8, frames between successive spawns while fire is held
SPAWN_OFFSET, 8, spawn Y is Ball_Y minus this
BULLET_W, 2, sprite width in pixels
BULLET_H, 4, sprite height in pixels

Ports:
Clk  in  1  system clock (50 MHz domain)
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse per frame, already synchronous to Clk
Start  in  1  game running; low clears the pool
keycodeshoot  in  8  USB shoot keycode; fire when equal to FIRE_KEY (8'h2C)
Ball_X  in  10  current ball X
Ball_Y  in  10  current ball Y
DrawX  in  10  pixel query X
DrawY  in  10  pixel query Y
bullet_on  out  1  registered: query pixel lies inside a valid bullet
active_count  out  clog2(NUM_BULLETS+1)  number of valid slots
pool_full  out  1  all slots valid
busy  out  1  high while a frame pass is running
spawn  out  1  one-cycle pulse when a slot is allocated
overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset:
  - All slots invalid, x = y = 0, cooldown = 0, state IDLE.
  - All outputs 0.
  - Takes effect immediately, including mid-pass.
  - No partial slot update survives.
- FSM states: IDLE, UPDATE, SPAWN.
  - IDLE: on frame_start go to UPDATE with idx = 0.
  - UPDATE: one slot per cycle, idx = 0 .. NUM_BULLETS-1, then go to SPAWN.
  - SPAWN: one cycle, then IDLE.
  - busy = (state != IDLE).
  - Pass latency: frame_start at cycle t → UPDATE at t+1 .. t+N → SPAWN at t+N+1 → IDLE at t+N+2.
- UPDATE per slot:
  - If Start = 0: invalidate the slot.
  - Else if valid and y < BULLET_SPEED: invalidate (no unsigned wrap).
  - Else if valid: y ← y − BULLET_SPEED.
  - x never changes.
- SPAWN:
  - If Start = 0: no spawn, cooldown ← 0.
  - Else if cooldown ≠ 0: cooldown decrements, no spawn.
  - Else if fire and not pool_full and Ball_Y ≥ SPAWN_OFFSET:
    - Allocate the lowest-index invalid slot: x ← Ball_X, y ← Ball_Y − SPAWN_OFFSET.
    - cooldown ← COOLDOWN; spawn pulses this cycle.
  - Otherwise (pool full, Ball_Y < SPAWN_OFFSET, or no fire): no spawn, cooldown stays 0.
  - A newly spawned bullet first moves in the next frame's pass.
- frame_start while busy: ignored (no restart, no queueing), overrun pulses for one cycle.
- Derived outputs:
  - active_count and pool_full are registered.
  - Both reflect slot state at the end of the previous cycle.
- Pixel query:
  - bullet_on at cycle c+1 reflects DrawX/DrawY at cycle c.
  - Condition: OR over valid slots of (DrawX ≥ x and DrawX − x < BULLET_W and DrawY ≥ y and DrawY − y < BULLET_H).
  - Compare in 10-bit unsigned arithmetic after the ≥ guard.
  - The query uses live slot registers and is valid during a pass; a one-frame tear on the slot being updated is acceptable.
- Keycode is sampled only in the SPAWN cycle; no edge detection (hold = autofire at the cooldown rate).

Decomposition:
Package rager_pkg:
- FIRE_KEY = 8'h2C
- coord_t (logic [9:0])
- bullet_t struct {valid, x, y}
- bullet_state_e enum {IDLE, UPDATE, SPAWN}

Sub-module bullet_pixel_test:
- Combinational hit test for one bullet_t against DrawX/DrawY, parameterised by BULLET_W and BULLET_H.
- Instantiated NUM_BULLETS times; the parent ORs and registers the results.

Test Plan:
- Reset_n low during UPDATE idx 2 → busy = 0, active_count = 0, bullet_on = 0 within the same cycle; the next frame_start starts from idx 0.
- Start = 1, Ball = (320,240), keycodeshoot = 8'h2C, frame_start → spawn pulses at cycle t+5; slot0 = (320,232), active_count = 1; after the next frame slot0.y = 228.
- Fire held for 10 frames from an empty pool → spawns in frames 0 and 9 only; active_count = 2 after frame 9.
- All 4 slots valid at y = 200, fire held, cooldown 0 → no spawn, pool_full = 1, cooldown stays 0; retire slot1 by setting its y = 3 → slot1 freed in UPDATE, the same pass's SPAWN reuses slot1.
- Slot at (100,50) → DrawX/DrawY = (101,53) gives bullet_on = 1 next cycle; (102,53), (99,50) and (101,54) give 0.
- frame_start pulsed at t and t+2 → a single pass runs, overrun = 1 at t+2, slot y decremented exactly once.
